// File: rtl/joy_serial_responder_if.sv
// rtl/joy_serial_responder_if.sv - serial joystick link bundle between reader (master) and responder (slave)
interface joy_serial_responder_if;
  logic [7:0] joy1_n;
  logic [7:0] joy2_n;
  logic       joy_clk;
  logic       joy_load_n;
  logic       joy_data;
  logic       frame_done;
  logic       link_active;
  logic [4:0] shift_count;

  modport master (
    output joy1_n, joy2_n, joy_clk, joy_load_n,
    input  joy_data, frame_done, link_active, shift_count
  );

  modport slave (
    input  joy1_n, joy2_n, joy_clk, joy_load_n,
    output joy_data, frame_done, link_active, shift_count
  );
endinterface

// File: rtl/joy_serial_responder.sv
// rtl/joy_serial_responder.sv - device end of the 16-bit serial joystick link
// Debounces two active-low button vectors and shifts them out under reader load/clock control.
module joy_serial_responder #(
  parameter int DEBOUNCE_DIV = 1024,
  parameter int LINK_TIMEOUT = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  joy_serial_responder_if.slave  bus
);

  localparam int DIV_W = (DEBOUNCE_DIV > 2) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [1:0]       clk_sync_q, load_sync_q;
  logic             clk_dly_q, load_dly_q;
  logic             clk_s, load_s, clk_rise, load_fall;

  logic [15:0]      btn_meta_q, btn_sync_q;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [15:0]      hist0_q, hist1_q, db_q, db_d, agree;

  logic [15:0]      sr_q, sr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             fd_q, fd_d;

  logic [CNT_W-1:0] to_q, to_d;
  logic             act_q, act_d;

  // Reader strobes idle high, so synchronizers reset to 1 to avoid false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      load_sync_q <= 2'b11;
      clk_dly_q   <= 1'b1;
      load_dly_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], bus.joy_clk};
      load_sync_q <= {load_sync_q[0], bus.joy_load_n};
      clk_dly_q   <= clk_sync_q[1];
      load_dly_q  <= load_sync_q[1];
    end
  end

  assign clk_s     = clk_sync_q[1];
  assign load_s    = load_sync_q[1];
  assign clk_rise  = clk_s & ~clk_dly_q;
  assign load_fall = ~load_s & load_dly_q;

  assign tick  = (div_q == DIV_W'(DEBOUNCE_DIV - 1));
  assign agree = ~(btn_sync_q ^ hist0_q) & ~(hist0_q ^ hist1_q);

  always_comb begin
    db_d = db_q;
    if (tick) begin
      db_d = (db_q & ~agree) | (btn_sync_q & agree);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q <= '1;
      btn_sync_q <= '1;
      div_q      <= '0;
      hist0_q    <= '1;
      hist1_q    <= '1;
      db_q       <= '1;
    end else begin
      btn_meta_q <= {bus.joy2_n, bus.joy1_n};
      btn_sync_q <= btn_meta_q;
      div_q      <= tick ? '0 : div_q + DIV_W'(1);
      db_q       <= db_d;
      if (tick) begin
        hist0_q <= btn_sync_q;
        hist1_q <= hist0_q;
      end
    end
  end

  // Load strobe dominates any concurrent shift clock.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    fd_d  = 1'b0;
    if (!load_s) begin
      sr_d  = db_q;
      cnt_d = 5'd0;
    end else if (clk_rise) begin
      sr_d = {1'b1, sr_q[15:1]};
      if (cnt_q != 5'd16) begin
        cnt_d = cnt_q + 5'd1;
      end
      fd_d = (cnt_q == 5'd15);
    end
  end

  always_comb begin
    to_d  = to_q;
    act_d = act_q;
    if (load_fall) begin
      to_d  = '0;
      act_d = 1'b1;
    end else begin
      if (to_q != CNT_W'(LINK_TIMEOUT)) begin
        to_d = to_q + CNT_W'(1);
      end
      if (to_d == CNT_W'(LINK_TIMEOUT)) begin
        act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '1;
      cnt_q <= 5'd0;
      fd_q  <= 1'b0;
      to_q  <= '0;
      act_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      fd_q  <= fd_d;
      to_q  <= to_d;
      act_q <= act_d;
    end
  end

  assign bus.joy_data    = sr_q[0];
  assign bus.frame_done  = fd_q;
  assign bus.link_active = act_q;
  assign bus.shift_count = cnt_q;

endmodule

// File: tb/tb_joy_serial_responder.sv
// tb/tb_joy_serial_responder.sv - scoreboard bench for joy_serial_responder
module tb_joy_serial_responder;
  localparam int DIV = 8;
  localparam int LT  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  joy_serial_responder_if bus();

  joy_serial_responder #(
    .DEBOUNCE_DIV(DIV),
    .LINK_TIMEOUT(LT),
    .CNT_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } exp_t;

  exp_t exp_q[$];
  logic smp = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  int   fd_base;

  always @(negedge clk) begin
    if (!rst && bus.frame_done) fd_cnt++;
  end

  // kind: 0 joy_data, 1 shift_count, 2 link_active, 3 frame_done pulse total
  always @(negedge clk) begin
    exp_t e;
    int   act;
    if (smp) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue, required an entry");
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          0:       act = int'(bus.joy_data);
          1:       act = int'(bus.shift_count);
          2:       act = int'(bus.link_active);
          default: act = fd_cnt;
        endcase
        if (act != e.exp) begin
          errors++;
          $display("FAIL %s: got %0d required %0d", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic chk(input int kind, input string name, input int exp);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    @(posedge clk); #1;
    exp_q.push_back(e);
    smp = 1'b1;
    @(negedge clk); #1;
    smp = 1'b0;
  endtask

  task automatic frame(input int n, input logic [15:0] exp, input string tag);
    bus.joy_load_n = 1'b0;
    repeat (16) @(posedge clk);
    #1 bus.joy_load_n = 1'b1;
    repeat (4) @(posedge clk);
    chk(0, {tag, "_b0"}, int'(exp[0]));
    for (int i = 1; i <= n; i++) begin
      bus.joy_clk = 1'b1;
      repeat (5) @(posedge clk);
      chk(0, $sformatf("%s_b%0d", tag, i), (i < 16) ? int'(exp[i[3:0]]) : 1);
      bus.joy_clk = 1'b0;
      repeat (8) @(posedge clk);
    end
  endtask

  task automatic pulse();
    bus.joy_clk = 1'b1;
    repeat (6) @(posedge clk);
    bus.joy_clk = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    bus.joy1_n     = 8'hFF;
    bus.joy2_n     = 8'hFF;
    bus.joy_clk    = 1'b0;
    bus.joy_load_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk(0, "rst_data", 1);
    chk(1, "rst_cnt", 0);
    chk(2, "rst_link", 0);
    chk(3, "rst_fd", 0);

    // all released; 15 shifts, then the 16th completes the frame
    repeat (40) @(posedge clk);
    fd_base = fd_cnt;
    frame(15, 16'hFFFF, "t1");
    chk(3, "t1_fd_after15", fd_base);
    chk(1, "t1_cnt15", 15);
    bus.joy_clk = 1'b1;
    repeat (5) @(posedge clk);
    chk(0, "t1_fill", 1);
    bus.joy_clk = 1'b0;
    repeat (8) @(posedge clk);
    chk(3, "t1_fd", fd_base + 1);
    chk(1, "t1_cnt16", 16);
    chk(2, "t1_link", 1);

    // up+start on joy1, fire1 on joy2
    bus.joy1_n = 8'h7E;
    bus.joy2_n = 8'hF7;
    repeat (4 * DIV + 8) @(posedge clk);
    fd_base = fd_cnt;
    frame(16, 16'hF77E, "t2");
    chk(3, "t2_fd", fd_base + 1);

    // short press is rejected, long press accepted
    bus.joy1_n = 8'hFF;
    bus.joy2_n = 8'hFF;
    repeat (4 * DIV + 8) @(posedge clk);
    bus.joy1_n[3] = 1'b0;
    repeat (2 * DIV) @(posedge clk);
    bus.joy1_n[3] = 1'b1;
    repeat (4 * DIV + 8) @(posedge clk);
    frame(16, 16'hFFFF, "t3a");
    bus.joy1_n[3] = 1'b0;
    repeat (4 * DIV) @(posedge clk);
    frame(16, 16'hFFF7, "t3b");

    // overrun: fill ones, saturated count, single frame_done
    fd_base = fd_cnt;
    frame(20, 16'hFFF7, "t4");
    chk(1, "t4_cnt", 16);
    chk(3, "t4_fd", fd_base + 1);

    // shift clock while load held low is ignored
    bus.joy1_n = 8'hF6;
    repeat (4 * DIV + 8) @(posedge clk);
    fd_base = fd_cnt;
    bus.joy_load_n = 1'b0;
    repeat (4) @(posedge clk);
    repeat (3) begin
      bus.joy_clk = 1'b1;
      repeat (4) @(posedge clk);
      bus.joy_clk = 1'b0;
      repeat (4) @(posedge clk);
    end
    chk(0, "t5_data", 0);
    chk(1, "t5_cnt", 0);
    chk(3, "t5_fd", fd_base);
    #1 bus.joy_load_n = 1'b1;
    repeat (4) @(posedge clk);

    // link timeout and recovery, then reset mid-frame
    chk(2, "t6_link_on", 1);
    repeat (LT + 10) @(posedge clk);
    chk(2, "t6_link_off", 0);
    bus.joy_load_n = 1'b0;
    repeat (2) @(posedge clk);
    chk(2, "t6_link_back", 1);
    repeat (12) @(posedge clk);
    #1 bus.joy_load_n = 1'b1;
    repeat (4) @(posedge clk);
    pulse();
    pulse();
    pulse();
    chk(1, "t6_cnt3", 3);
    chk(0, "t6_data3", 0);
    rst = 1'b1;
    chk(0, "t6_rst_data", 1);
    chk(1, "t6_rst_cnt", 0);
    chk(2, "t6_rst_link", 0);
    #1 rst = 1'b0;

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
